// File: rtl/ddr_arb_pkg.sv
// Shared types and constants for the two-master DDR AXI arbiter.
package ddr_arb_pkg;

    localparam int SID_W       = 5;
    localparam int MID_W       = SID_W + 1;
    localparam int ARB_IDX_BIT = SID_W;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2
    } wstate_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker with a grant lock and a priority pointer.
// While lock is high the previously captured grant is held; gnt_vld then
// simply follows that requester's valid.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       adv,
    output logic       gnt_idx,
    output logic       gnt_vld
);

    logic prio_r;
    logic gnt_r;
    logic pick_s;

    // Round-robin pick: the pointed-to port first, otherwise the other one.
    always_comb begin
        pick_s = prio_r;
        if (req[prio_r]) begin
            pick_s = prio_r;
        end else if (req[~prio_r]) begin
            pick_s = ~prio_r;
        end else begin
            pick_s = prio_r;
        end
    end

    // Grant selection: the held grant while locked, the fresh pick otherwise.
    always_comb begin
        gnt_idx = pick_s;
        if (lock) begin
            gnt_idx = gnt_r;
        end else begin
            gnt_idx = pick_s;
        end
        gnt_vld = req[gnt_idx];
    end

    // Capture the grant whenever unlocked; move the pointer on each advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_r  <= 1'b0;
            prio_r <= 1'b0;
        end else begin
            if (!lock && (req != 2'b00)) begin
                gnt_r <= pick_s;
            end else begin
                gnt_r <= gnt_r;
            end
            if (adv) begin
                prio_r <= ~gnt_idx;
            end else begin
                prio_r <= prio_r;
            end
        end
    end

endmodule

// File: rtl/ddr_axi_arb.sv
// Two-master AXI4 arbiter onto a single DDR master port. Reads and writes
// are arbitrated independently; the winning port index becomes the top ID
// bit so that R and B can be steered back without any tracking state.
module ddr_axi_arb #(
    parameter int SID_W  = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rstn,
    // CPU port, index 0
    input  logic [SID_W-1:0]    s0_awid,
    input  logic [ADDR_W-1:0]   s0_awaddr,
    input  logic [7:0]          s0_awlen,
    input  logic [2:0]          s0_awsize,
    input  logic [1:0]          s0_awburst,
    input  logic                s0_awvalid,
    output logic                s0_awready,
    input  logic [DATA_W-1:0]   s0_wdata,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    input  logic                s0_wlast,
    input  logic                s0_wvalid,
    output logic                s0_wready,
    output logic [SID_W-1:0]    s0_bid,
    output logic [1:0]          s0_bresp,
    output logic                s0_bvalid,
    input  logic                s0_bready,
    input  logic [SID_W-1:0]    s0_arid,
    input  logic [ADDR_W-1:0]   s0_araddr,
    input  logic [7:0]          s0_arlen,
    input  logic [2:0]          s0_arsize,
    input  logic [1:0]          s0_arburst,
    input  logic                s0_arvalid,
    output logic                s0_arready,
    output logic [SID_W-1:0]    s0_rid,
    output logic [DATA_W-1:0]   s0_rdata,
    output logic [1:0]          s0_rresp,
    output logic                s0_rlast,
    output logic                s0_rvalid,
    input  logic                s0_rready,
    // DMA port, index 1
    input  logic [SID_W-1:0]    s1_awid,
    input  logic [ADDR_W-1:0]   s1_awaddr,
    input  logic [7:0]          s1_awlen,
    input  logic [2:0]          s1_awsize,
    input  logic [1:0]          s1_awburst,
    input  logic                s1_awvalid,
    output logic                s1_awready,
    input  logic [DATA_W-1:0]   s1_wdata,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    input  logic                s1_wlast,
    input  logic                s1_wvalid,
    output logic                s1_wready,
    output logic [SID_W-1:0]    s1_bid,
    output logic [1:0]          s1_bresp,
    output logic                s1_bvalid,
    input  logic                s1_bready,
    input  logic [SID_W-1:0]    s1_arid,
    input  logic [ADDR_W-1:0]   s1_araddr,
    input  logic [7:0]          s1_arlen,
    input  logic [2:0]          s1_arsize,
    input  logic [1:0]          s1_arburst,
    input  logic                s1_arvalid,
    output logic                s1_arready,
    output logic [SID_W-1:0]    s1_rid,
    output logic [DATA_W-1:0]   s1_rdata,
    output logic [1:0]          s1_rresp,
    output logic                s1_rlast,
    output logic                s1_rvalid,
    input  logic                s1_rready,
    // DDR master port
    output logic [SID_W:0]      m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [SID_W:0]      m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [SID_W:0]      m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [SID_W:0]      m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready
);

    import ddr_arb_pkg::*;

    // ------------------------------------------------------------------
    // Read address path
    // ------------------------------------------------------------------
    logic ar_lock_r;
    logic ar_idx_s;
    logic ar_vld_s;

    rr_arb2 u_ar_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     ({s1_arvalid, s0_arvalid}),
        .lock    (ar_lock_r),
        .adv     (m_arvalid & m_arready),
        .gnt_idx (ar_idx_s),
        .gnt_vld (ar_vld_s)
    );

    // Hold the read grant while an address is waiting for m_arready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_lock_r <= 1'b0;
        end else begin
            ar_lock_r <= m_arvalid & ~m_arready;
        end
    end

    // Steer the granted AR channel to the master and its ready back.
    always_comb begin
        m_arvalid  = ar_vld_s;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        if (ar_idx_s) begin
            m_arid     = {1'b1, s1_arid};
            m_araddr   = s1_araddr;
            m_arlen    = s1_arlen;
            m_arsize   = s1_arsize;
            m_arburst  = s1_arburst;
            s1_arready = m_arready & ar_vld_s;
        end else begin
            m_arid     = {1'b0, s0_arid};
            m_araddr   = s0_araddr;
            m_arlen    = s0_arlen;
            m_arsize   = s0_arsize;
            m_arburst  = s0_arburst;
            s0_arready = m_arready & ar_vld_s;
        end
    end

    // Route R beats back by the port bit of the returned ID.
    always_comb begin
        s0_rid    = m_rid[SID_W-1:0];
        s1_rid    = m_rid[SID_W-1:0];
        s0_rdata  = m_rdata;
        s1_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s1_rresp  = m_rresp;
        s0_rlast  = m_rlast;
        s1_rlast  = m_rlast;
        s0_rvalid = m_rvalid & ~m_rid[SID_W];
        s1_rvalid = m_rvalid &  m_rid[SID_W];
        if (m_rid[SID_W]) begin
            m_rready = s1_rready;
        end else begin
            m_rready = s0_rready;
        end
    end

    // Route B responses back by the port bit, independent of the write FSM.
    always_comb begin
        s0_bid    = m_bid[SID_W-1:0];
        s1_bid    = m_bid[SID_W-1:0];
        s0_bresp  = m_bresp;
        s1_bresp  = m_bresp;
        s0_bvalid = m_bvalid & ~m_bid[SID_W];
        s1_bvalid = m_bvalid &  m_bid[SID_W];
        if (m_bid[SID_W]) begin
            m_bready = s1_bready;
        end else begin
            m_bready = s0_bready;
        end
    end

    // ------------------------------------------------------------------
    // Write path: one burst at a time, AW then all of its W beats
    // ------------------------------------------------------------------
    wstate_e state_r;
    wstate_e state_nx;
    logic    wsel_r;
    logic    aw_idx_s;
    logic    aw_vld_s;
    logic    sel_wvalid_s;
    logic    w_last_hs_s;

    rr_arb2 u_aw_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     ({s1_awvalid, s0_awvalid}),
        .lock    (state_r != W_IDLE),
        .adv     (w_last_hs_s),
        .gnt_idx (aw_idx_s),
        .gnt_vld (aw_vld_s)
    );

    // Write FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= W_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Latch the write winner on leaving idle; it owns AW and W until wlast.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wsel_r <= 1'b0;
        end else if ((state_r == W_IDLE) && aw_vld_s) begin
            wsel_r <= aw_idx_s;
        end else begin
            wsel_r <= wsel_r;
        end
    end

    // Write FSM next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            W_IDLE: begin
                if (aw_vld_s) begin
                    state_nx = W_ADDR;
                end else begin
                    state_nx = W_IDLE;
                end
            end
            W_ADDR: begin
                if (m_awready) begin
                    state_nx = W_DATA;
                end else begin
                    state_nx = W_ADDR;
                end
            end
            W_DATA: begin
                if (w_last_hs_s) begin
                    state_nx = W_IDLE;
                end else begin
                    state_nx = W_DATA;
                end
            end
            default: begin
                state_nx = W_IDLE;
            end
        endcase
    end

    // Write FSM outputs: AW/W muxed from the selected port, gated by state.
    always_comb begin
        m_awvalid   = 1'b0;
        s0_awready  = 1'b0;
        s1_awready  = 1'b0;
        m_wvalid    = 1'b0;
        s0_wready   = 1'b0;
        s1_wready   = 1'b0;
        w_last_hs_s = 1'b0;
        if (wsel_r) begin
            m_awid       = {1'b1, s1_awid};
            m_awaddr     = s1_awaddr;
            m_awlen      = s1_awlen;
            m_awsize     = s1_awsize;
            m_awburst    = s1_awburst;
            m_wdata      = s1_wdata;
            m_wstrb      = s1_wstrb;
            m_wlast      = s1_wlast;
            sel_wvalid_s = s1_wvalid;
        end else begin
            m_awid       = {1'b0, s0_awid};
            m_awaddr     = s0_awaddr;
            m_awlen      = s0_awlen;
            m_awsize     = s0_awsize;
            m_awburst    = s0_awburst;
            m_wdata      = s0_wdata;
            m_wstrb      = s0_wstrb;
            m_wlast      = s0_wlast;
            sel_wvalid_s = s0_wvalid;
        end
        case (state_r)
            W_ADDR: begin
                m_awvalid = 1'b1;
                if (wsel_r) begin
                    s1_awready = m_awready;
                end else begin
                    s0_awready = m_awready;
                end
            end
            W_DATA: begin
                m_wvalid = sel_wvalid_s;
                if (wsel_r) begin
                    s1_wready = m_wready;
                end else begin
                    s0_wready = m_wready;
                end
                w_last_hs_s = sel_wvalid_s & m_wready & m_wlast;
            end
            default: begin
                m_awvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/ddr_axi_arb.md
# ddr_axi_arb

Two-master AXI4 arbiter that shares the single external DDR master port (6-bit ID, 32-bit address/data, 8-bit AxLEN) between the CPU memory port and a DMA requester such as the MAC. It sits in `cpu_wrap` between the internal masters and the `ddr_m` AXI port.

- Reads and writes are arbitrated independently, round-robin.
- Each slave port uses a 5-bit ID; the arbiter prepends the port index as ID bit 5.
- Responses are routed back by that bit.

## Interface
Parameters:
- `SID_W`, default 5: slave-port ID width; the master-port ID is `SID_W+1`.
- `ADDR_W`, default 32: address width, all ports.
- `DATA_W`, default 32: data width, all ports; strobe width is `DATA_W/8`.

Ports:
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous active-low reset.
- `s0_*`  slave  AXI4 AW/W/B/AR/R  CPU port, index 0.
  - Signals: id, addr, len[7:0], size[2:0], burst[1:0], valid/ready, wdata, wstrb, wlast, resp[1:0], rdata, rlast.
- `s1_*`  slave  AXI4 AW/W/B/AR/R  DMA port, index 1, same signal set as `s0_*`.
- `m_*`  master  AXI4 AW/W/B/AR/R  to the DDR controller, ID width `SID_W+1`.

## Operation
Read path:
- A 2-way round-robin picker selects among `s0_arvalid` and `s1_arvalid`.
- The grant is locked while `m_arvalid && !m_arready`, so the address never changes mid-handshake.
- `m_arid = {idx, sX_arid}`.
- The priority pointer moves to the other port after each AR handshake.
- Multiple reads may be outstanding from both ports.
- R beats are routed by `m_rid[SID_W]`: `m_rready` = selected `sX_rready`, and the other port's `rvalid` = 0.

Write path FSM, with states `W_IDLE`, `W_ADDR`, `W_DATA`:
- `W_IDLE`: when any `awvalid` is high, run the picker and register the winner into `wsel`, then go to `W_ADDR`. `m_awvalid` = 0.
- `W_ADDR`: drive `m_aw*` from `wsel` with `m_awid = {wsel, awid}`. On `m_awready` go to `W_DATA`; `sX_awready` pulses for the `wsel` port only.
- `W_DATA`: forward W from `wsel` only; the other port's `wready` = 0.
  - On a W handshake with `wlast`, advance the pointer and go to `W_IDLE`.
  - W beats from the `wsel` port presented during `W_ADDR` are stalled, with `wready` = 0.

Write response path:
- B is routed by `m_bid[SID_W]`; `bid` is stripped to `SID_W` bits.
- B is independent of the FSM, so B for a burst may return while the next AW is in arbitration.

General rules:
- `s*_awready`, `s*_arready` and `s*_wready` are combinational from `m_*ready`, gated by the grant.
- Fields are passed through unmodified: no width conversion, burst splitting, or response merging.

## Timing
Reset values:
- `wsel` = 0, read grant = 0, both priority pointers = port 0, FSM = `W_IDLE`.
- All `m_*valid`, `s*_*valid` and `s*_*ready` = 0.

Latency:
- AR: 0 cycles; `m_arvalid` is in the same cycle as `sX_arvalid` when the port wins.
- AW: 1 cycle added by the `W_IDLE`→`W_ADDR` registration.
- W, R, B: 0 cycles, combinational routing.

Boundary conditions:
- Simultaneous requests: the pointer decides; after reset, port 0 wins first.
- A single requester is granted every time.
- A port that drops `arvalid` before its handshake (illegal AXI) is not protected; the lock only holds while valid.
- `len` = 0: `wlast` is on the first beat and the FSM returns to `W_IDLE` in the same handshake cycle.
- Back-to-back bursts: minimum 1 idle cycle on `m_awvalid` between write bursts.
- Reset mid-burst: all state returns to reset values immediately. Partial bursts are abandoned; recovery is the system's job.

## Structure
- Package `ddr_arb_pkg`:
  - `wstate_e` enum.
  - `SID_W` and `MID_W` localparams.
  - `ARB_IDX_BIT = SID_W`.
- Sub-module `rr_arb2`: inputs req[1:0], lock, adv; outputs gnt_idx, gnt_vld; holds the priority flop. It is instantiated twice, for read and write.
- Top level: the write FSM plus the routing muxes.

## Test plan
- `s0` and `s1` both assert AR (ids 3 and 7) in the same cycle with `m_arready`=1 → `m_arid` = 0x03 then 0x27 on consecutive cycles; a third `s0` AR comes after `s1`.
- `m_arready` held 0 for 5 cycles while `s1` raises AR → `m_araddr`/`m_arid` stay stable on the `s0` request until the handshake.
- `s0` 4-beat write and `s1` 1-beat write issued together →
  - `s0` burst completes before `m_awvalid` rises for `s1`.
  - `s1_wready` = 0 throughout the `s0` burst.
  - The `s1` AW is issued ≥1 cycle after the `s0` wlast.
- Interleaved responses: R beats with `m_rid` 0x21,0x01,0x21 → `s1`,`s0`,`s1` receive them with `rid`=1; `m_bid`=0x25 → `s1_bid`=5 only.
- `rstn` asserted during beat 2 of an 8-beat write → FSM = `W_IDLE` and all valids/readies 0 immediately; after release, a new `s1` write is granted first-come.
- 1000 random AR/AW from both ports with random ready → the grant counts differ by ≤1, and no ID or data misroute, checked by a scoreboard.
